// File: rtl/store_buffer_pkg.sv
// Shared definitions for the MEM-stage store buffer: FSM state type and default geometry.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_PTR_W = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } sb_state_e;

endpackage

// File: rtl/store_buffer_match.sv
// Associative lookup over the store buffer entries; reports the youngest valid
// entry whose address equals the request address.
module store_buf_match #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2,
  parameter int unsigned ADDR_W = 32
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
  input  logic [DEPTH-1:0]             entry_valid,
  input  logic [PTR_W-1:0]             head,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         hit,
  output logic [PTR_W-1:0]             idx
);

  logic [PTR_W-1:0] pos;

  // Walk oldest to youngest from head; later matches overwrite earlier ones.
  always_comb begin
    hit = 1'b0;
    idx = head;
    pos = head;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pos = head + PTR_W'(k);
      if (entry_valid[pos] && (entry_addr[pos] == req_addr)) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer in front of the single-port data memory: posts stores,
// forwards to loads, and drains one entry per cycle when the port is free.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned PTR_W  = SB_PTR_W,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              St_Valid,
  input  logic              Ld_Valid,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [DATA_W-1:0] Req_Data,
  output logic [DATA_W-1:0] Ld_Data,
  output logic              Stall,
  input  logic              Flush,
  output logic              Flush_Done,
  output logic              Mem_Write,
  output logic              Mem_Read,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Empty,
  output logic              Full,
  output logic [PTR_W:0]    Count
);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             valid_q;
  logic [PTR_W-1:0]             head_q, tail_q;
  logic [PTR_W:0]               count_q;
  sb_state_e                    state_q, state_d;

  logic             hit, drain, accept;
  logic [PTR_W-1:0] match_idx;

  store_buf_match #(
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .ADDR_W (ADDR_W)
  ) u_match (
    .entry_addr  (addr_q),
    .entry_valid (valid_q),
    .head        (head_q),
    .req_addr    (Req_Addr),
    .hit         (hit),
    .idx         (match_idx)
  );

  assign Empty = (count_q == '0);
  assign Full  = (count_q == (PTR_W+1)'(DEPTH));
  assign Count = count_q;

  // A store only steals the drain slot when the buffer is full, so back-to-back
  // stores accumulate and a full buffer still never stalls a store.
  always_comb begin
    state_d    = state_q;
    drain      = 1'b0;
    accept     = 1'b0;
    Mem_Read   = 1'b0;
    Stall      = 1'b0;
    Flush_Done = 1'b0;
    Ld_Data    = '0;
    if (!RST) begin
      case (state_q)
        ST_RUN: begin
          if (Flush) state_d = ST_FLUSH;
          if (Ld_Valid) begin
            if (hit) begin
              Ld_Data = data_q[match_idx];
              drain   = !Empty;
            end else if (!Full) begin
              Mem_Read = 1'b1;
              Ld_Data  = Mem_RData;
            end else begin
              drain = 1'b1;
              Stall = 1'b1;
            end
          end else if (St_Valid) begin
            drain  = Full;
            accept = 1'b1;
          end else begin
            drain = !Empty;
          end
        end
        ST_FLUSH: begin
          drain = !Empty;
          Stall = St_Valid | Ld_Valid;
          if (Empty) begin
            Flush_Done = 1'b1;
            state_d    = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign Mem_Write = drain;
  assign Mem_Addr  = Mem_Read ? Req_Addr : addr_q[head_q];
  assign Mem_WData = data_q[head_q];

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      // When full, head==tail: the accept write must land after the drain clear.
      if (accept) begin
        addr_q[tail_q]  <= Req_Addr;
        data_q[tail_q]  <= Req_Data;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      case ({accept, drain})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a word memory model and a queue of
// expected memory writes in drain order.
module tb_store_buffer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        St_Valid = 1'b0, Ld_Valid = 1'b0, Flush = 1'b0;
  logic [31:0] Req_Addr = '0, Req_Data = '0;
  logic [31:0] Ld_Data, Mem_Addr, Mem_WData, Mem_RData;
  logic        Stall, Flush_Done, Mem_Write, Mem_Read, Empty, Full;
  logic [2:0]  Count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         sbq[$];
  logic [31:0] mem [0:255];
  int          errors = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  store_buffer #(.DEPTH(4), .PTR_W(2), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .St_Valid   (St_Valid),
    .Ld_Valid   (Ld_Valid),
    .Req_Addr   (Req_Addr),
    .Req_Data   (Req_Data),
    .Ld_Data    (Ld_Data),
    .Stall      (Stall),
    .Flush      (Flush),
    .Flush_Done (Flush_Done),
    .Mem_Write  (Mem_Write),
    .Mem_Read   (Mem_Read),
    .Mem_Addr   (Mem_Addr),
    .Mem_WData  (Mem_WData),
    .Mem_RData  (Mem_RData),
    .Empty      (Empty),
    .Full       (Full),
    .Count      (Count)
  );

  assign Mem_RData = mem[Mem_Addr[7:0]];

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h20] <= 32'h77;
    end else if (Mem_Write) begin
      mem[Mem_Addr[7:0]] <= Mem_WData;
    end
  end

  always @(posedge CLK) begin
    assert (!(St_Valid && Ld_Valid)) else $error("FAIL illegal_st_ld observed=1 expected=0");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's request at the falling edge; any drain in that cycle is
  // compared against the oldest outstanding store.
  task automatic drive(input logic rst, input logic st, input logic ld, input logic fl,
                       input logic [31:0] a, input logic [31:0] d);
    wr_t exp;
    @(negedge CLK);
    RST = rst; St_Valid = st; Ld_Valid = ld; Flush = fl; Req_Addr = a; Req_Data = d;
    #2;
    if (Mem_Write) begin
      exp = (sbq.size() > 0) ? sbq.pop_front() : '1;
      chk("mem_write", {Mem_Addr, Mem_WData}, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, 1'b0, 1'b0, a, d);
    sbq.push_back({a, d});
  endtask

  task automatic load(input logic [31:0] a);
    drive(1'b0, 1'b0, 1'b1, 1'b0, a, '0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic flush_pulse();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  initial begin
    // reset
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, '0);
    chk("rst_memwrite", Mem_Write, 0);
    chk("rst_memread", Mem_Read, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_flushdone", Flush_Done, 0);
    chk("rst_lddata", Ld_Data, 0);
    idle();
    chk("init_empty", Empty, 1);
    chk("init_count", Count, 0);
    chk("init_full", Full, 0);
    chk("init_memwrite", Mem_Write, 0);
    chk("init_memread", Mem_Read, 0);
    chk("init_stall", Stall, 0);

    // store then forward
    store(32'h10, 32'hDEAD);
    chk("t2_st_stall", Stall, 0);
    load(32'h10);
    chk("t2_fwd", Ld_Data, 32'hDEAD);
    chk("t2_noread", Mem_Read, 0);
    chk("t2_drain", Mem_Write, 1);
    idle();
    chk("t2_empty", Empty, 1);
    chk("t2_mem", mem[8'h10], 32'hDEAD);
    load(32'h10);
    chk("t2_rd", Mem_Read, 1);
    chk("t2_rd_data", Ld_Data, 32'hDEAD);

    // same address twice: youngest wins
    store(32'h5, 32'h1);
    store(32'h5, 32'h2);
    chk("t3_count", Count, 1);
    load(32'h5);
    chk("t3_youngest", Ld_Data, 32'h2);
    chk("t3_noread", Mem_Read, 0);
    idle();
    idle();
    chk("t3_empty", Empty, 1);
    chk("t3_mem", mem[8'h5], 32'h2);
    load(32'h5);
    chk("t3_rd_data", Ld_Data, 32'h2);

    // full buffer: store drains in same cycle, load miss stalls one cycle
    store(32'h30, 32'hA0);
    store(32'h31, 32'hA1);
    store(32'h32, 32'hA2);
    store(32'h33, 32'hA3);
    store(32'h34, 32'hA4);
    chk("t4_full", Full, 1);
    chk("t4_count_full", Count, 4);
    chk("t4_st_stall", Stall, 0);
    chk("t4_st_drain", Mem_Write, 1);
    load(32'h20);
    chk("t4_count_kept", Count, 4);
    chk("t4_stall", Stall, 1);
    chk("t4_stall_write", Mem_Write, 1);
    chk("t4_stall_noread", Mem_Read, 0);
    load(32'h20);
    chk("t4_retry_stall", Stall, 0);
    chk("t4_retry_read", Mem_Read, 1);
    chk("t4_retry_data", Ld_Data, 32'h77);
    chk("t4_retry_count", Count, 3);
    idle();
    idle();
    idle();
    idle();
    chk("t4_empty", Empty, 1);

    // flush with three entries
    store(32'h40, 32'hB0);
    store(32'h41, 32'hB1);
    store(32'h42, 32'hB2);
    flush_pulse();
    chk("t5_c0_write", Mem_Write, 1);
    chk("t5_c0_done", Flush_Done, 0);
    load(32'h40);
    chk("t5_c1_stall", Stall, 1);
    chk("t5_c1_write", Mem_Write, 1);
    chk("t5_c1_noread", Mem_Read, 0);
    idle();
    chk("t5_c2_write", Mem_Write, 1);
    chk("t5_c2_done", Flush_Done, 0);
    idle();
    chk("t5_c3_done", Flush_Done, 1);
    chk("t5_c3_nowrite", Mem_Write, 0);
    chk("t5_c3_empty", Empty, 1);
    load(32'h41);
    chk("t5_run_stall", Stall, 0);
    chk("t5_run_done", Flush_Done, 0);
    chk("t5_run_read", Mem_Read, 1);
    chk("t5_run_data", Ld_Data, 32'hB1);

    // flush while already empty
    flush_pulse();
    chk("fe_c0_done", Flush_Done, 0);
    idle();
    chk("fe_c1_done", Flush_Done, 1);
    idle();
    chk("fe_c2_done", Flush_Done, 0);

    // reset in the middle of a flush discards the remaining entries
    store(32'h50, 32'hC0);
    store(32'h51, 32'hC1);
    store(32'h52, 32'hC2);
    store(32'h53, 32'hC3);
    flush_pulse();
    chk("t6_c0_write", Mem_Write, 1);
    idle();
    chk("t6_c1_write", Mem_Write, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h52, '0);
    chk("t6_rst_write", Mem_Write, 0);
    chk("t6_rst_stall", Stall, 0);
    chk("t6_rst_lddata", Ld_Data, 0);
    sbq.delete();
    idle();
    chk("t6_empty", Empty, 1);
    chk("t6_count", Count, 0);
    chk("t6_nowrite", Mem_Write, 0);
    chk("t6_done", Flush_Done, 0);
    idle();
    chk("t6_nowrite2", Mem_Write, 0);
    load(32'h52);
    chk("t6_run_stall", Stall, 0);
    chk("t6_run_read", Mem_Read, 1);
    chk("t6_discarded", Ld_Data, 0);

    chk("sb_drained", sbq.size(), 0);
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
